// File: rtl/wiscsc15_dmem_resp.sv
// wiscsc15_dmem_resp: multi-cycle data memory with ready/stall handshake and error pulses
// Ports: clk, rst (async, active-high); dm_read/dm_write/dm_addr/dm_wdata request in;
//        dm_rdata (valid with dm_ready), dm_ready (completion pulse), stall (pipeline hold),
//        dm_err (pulse alongside dm_ready on a read+write conflict or out-of-range address).
module wiscsc15_dmem_resp #(
    parameter int LATENCY = 2,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_ready,
    output logic        stall,
    output logic        dm_err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t         state, state_n;
    logic [3:0]     cnt, cnt_n;
    logic           lat_rd, lat_wr, lat_err;
    logic [AW-1:0]  lat_idx;
    logic [15:0]    lat_wdata;
    logic [15:0]    mem [2**AW];
    logic           req, req_err, accept, enter_done;
    logic           a_rd, a_wr, a_err;
    logic [AW-1:0]  a_idx;
    logic [15:0]    a_wdata;
    assign req     = dm_read | dm_write;
    // Any address bit above the index width makes the request an error, so nothing aliases.
    assign req_err = (dm_read & dm_write) | ((dm_addr >> AW) != 16'd0);
    assign accept  = (state == IDLE) & req;
    assign stall   = ~rst & (accept | (state == WAIT));
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: if (req) begin
                state_n = (LATENCY == 1) ? DONE : WAIT;
                cnt_n   = 4'(LATENCY - 1);
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // With LATENCY=1 the access happens on the acceptance edge itself, before the latches
    // hold anything, so the live request is used from IDLE and the latches otherwise.
    assign a_rd       = (state == IDLE) ? dm_read            : lat_rd;
    assign a_wr       = (state == IDLE) ? dm_write           : lat_wr;
    assign a_err      = (state == IDLE) ? req_err            : lat_err;
    assign a_idx      = (state == IDLE) ? dm_addr[AW-1:0]    : lat_idx;
    assign a_wdata    = (state == IDLE) ? dm_wdata           : lat_wdata;
    assign enter_done = ~rst & (state_n == DONE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            dm_ready  <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_rd    <= dm_read;
                lat_wr    <= dm_write;
                lat_err   <= req_err;
                lat_idx   <= dm_addr[AW-1:0];
                lat_wdata <= dm_wdata;
            end
            dm_ready <= enter_done;
            dm_err   <= enter_done & a_err;
            dm_rdata <= (enter_done & a_rd & ~a_err) ? mem[a_idx] : '0;
        end
    end
    // Array contents survive reset; an aborted write never reaches here.
    always_ff @(posedge clk) begin
        if (enter_done & a_wr & ~a_err) mem[a_idx] <= a_wdata;
    end
endmodule

// File: tb/tb_wiscsc15_dmem_resp.sv
// tb_wiscsc15_dmem_resp: directed self-checking bench for two instances (LATENCY=2 and LATENCY=1)
module tb_wiscsc15_dmem_resp;
    logic        clk = 0;
    logic        rst = 0;
    logic        rd [2];
    logic        wr [2];
    logic [15:0] addr [2];
    logic [15:0] wd [2];
    logic [15:0] rdata [2];
    logic        ready [2];
    logic        stall [2];
    logic        err [2];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wiscsc15_dmem_resp #(.LATENCY(2), .AW(8)) dut0 (
        .clk(clk), .rst(rst), .dm_read(rd[0]), .dm_write(wr[0]), .dm_addr(addr[0]),
        .dm_wdata(wd[0]), .dm_rdata(rdata[0]), .dm_ready(ready[0]), .stall(stall[0]), .dm_err(err[0]));
    wiscsc15_dmem_resp #(.LATENCY(1), .AW(8)) dut1 (
        .clk(clk), .rst(rst), .dm_read(rd[1]), .dm_write(wr[1]), .dm_addr(addr[1]),
        .dm_wdata(wd[1]), .dm_rdata(rdata[1]), .dm_ready(ready[1]), .stall(stall[1]), .dm_err(err[1]));

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 free, 1 access outstanding, 2 completion cycle.
    int          ph [2]        = '{0, 0};
    int          left [2]      = '{0, 0};
    bit          m_rd [2], m_wr [2];
    logic [15:0] m_a [2], m_wd [2];
    logic [15:0] mem_m [2][256];
    bit          known [2][256];
    bit          exp_ready [2] = '{0, 0};
    bit          exp_err [2]   = '{0, 0};
    bit          exp_known [2] = '{1, 1};
    logic [15:0] exp_rdata [2] = '{16'h0, 16'h0};

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            exp_ready[d] = 0;
            exp_err[d]   = 0;
            exp_rdata[d] = 16'h0;
            exp_known[d] = 1;
            if (rst) ph[d] = 0;
            else if (ph[d] == 2) ph[d] = 0;
            else begin
                if (ph[d] == 0 && (rd[d] || wr[d])) begin
                    m_rd[d] = rd[d]; m_wr[d] = wr[d]; m_a[d] = addr[d]; m_wd[d] = wd[d];
                    left[d] = lat(d);
                    ph[d]   = 1;
                end
                if (ph[d] == 1) begin
                    left[d]--;
                    if (left[d] == 0) begin
                        ph[d]        = 2;
                        exp_ready[d] = 1;
                        if ((m_rd[d] && m_wr[d]) || m_a[d] > 16'h00FF) exp_err[d] = 1;
                        else if (m_wr[d]) begin
                            mem_m[d][m_a[d][7:0]] = m_wd[d];
                            known[d][m_a[d][7:0]] = 1;
                        end else begin
                            exp_rdata[d] = mem_m[d][m_a[d][7:0]];
                            exp_known[d] = known[d][m_a[d][7:0]];
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("ready%0d", d), 16'(ready[d]), 16'(exp_ready[d]));
            chk($sformatf("err%0d", d), 16'(err[d]), 16'(exp_err[d]));
            chk($sformatf("stall%0d", d), 16'(stall[d]),
                16'(!rst && ((ph[d] == 0 && (rd[d] || wr[d])) || ph[d] == 1)));
            if (exp_known[d]) chk($sformatf("rdata%0d", d), rdata[d], exp_rdata[d]);
        end
    end

    task automatic xfer(input int d, input bit r, input bit w, input logic [15:0] a,
                        input logic [15:0] dat, input string nm, input logic [15:0] xd, input bit xe);
        int n = 0;
        int st = 0;
        bit seen = 0;
        logic [15:0] got = 16'h0;
        logic ge = 0;
        @(posedge clk); #1;
        rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = dat;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (stall[d]) st++;
            if (ready[d]) begin
                seen = 1;
                got  = rdata[d];
                ge   = err[d];
            end
        end
        @(posedge clk); #1;
        rd[d] = 0; wr[d] = 0;
        chk({nm, "_latency"}, 16'(n), 16'(lat(d) + 1));
        chk({nm, "_stallcyc"}, 16'(st), 16'(lat(d)));
        chk({nm, "_data"}, got, xd);
        chk({nm, "_err"}, 16'(ge), 16'(xe));
    endtask

    initial begin
        int cnt;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 0; wr[d] = 0; addr[d] = 16'h0; wd[d] = 16'h0;
        end
        #1 rst = 1;
        rd[0] = 1;
        repeat (2) @(negedge clk);
        chk("reset_stall", 16'(stall[0]), 16'h0);
        chk("reset_ready", 16'(ready[0]), 16'h0);
        chk("reset_rdata", rdata[0], 16'h0);
        rd[0] = 0;
        @(posedge clk); #1 rst = 0;

        xfer(0, 0, 1, 16'h0005, 16'hBEEF, "wr5", 16'h0, 0);
        xfer(0, 1, 0, 16'h0005, 16'h0, "rd5", 16'hBEEF, 0);
        xfer(0, 0, 1, 16'h0007, 16'h00AA, "wr7", 16'h0, 0);
        xfer(0, 1, 1, 16'h0007, 16'hFFFF, "conflict7", 16'h0, 1);
        xfer(0, 1, 0, 16'h0007, 16'h0, "rd7", 16'h00AA, 0);
        xfer(0, 0, 1, 16'h0000, 16'h0A0A, "wr0", 16'h0, 0);
        xfer(0, 1, 0, 16'h0100, 16'h0, "oob_rd", 16'h0, 1);
        xfer(0, 0, 1, 16'h0100, 16'h5555, "oob_wr", 16'h0, 1);
        xfer(0, 1, 0, 16'h0000, 16'h0, "rd0", 16'h0A0A, 0);

        xfer(1, 0, 1, 16'h0003, 16'h1234, "l1_wr3", 16'h0, 0);
        @(posedge clk); #1;
        rd[1] = 1; addr[1] = 16'h0003;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready[1]) begin
                cnt++;
                chk("b2b_data", rdata[1], 16'h1234);
            end
        end
        @(posedge clk); #1 rd[1] = 0;
        chk("b2b_count", 16'(cnt), 16'd4);

        xfer(0, 0, 1, 16'h0002, 16'h1111, "wr2", 16'h0, 0);
        @(posedge clk); #1;
        wr[0] = 1; addr[0] = 16'h0002; wd[0] = 16'h7777;
        @(posedge clk); #1;
        chk("wait_stall", 16'(stall[0]), 16'h1);
        rst = 1; wr[0] = 0;
        #1;
        chk("abort_stall", 16'(stall[0]), 16'h0);
        chk("abort_rdata", rdata[0], 16'h0);
        @(posedge clk); #1 rst = 0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready[0]) cnt++;
        end
        chk("abort_no_ready", 16'(cnt), 16'h0);
        xfer(0, 1, 0, 16'h0002, 16'h0, "rd2", 16'h1111, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
